axi_line_port: RTL and testbench

- Parametrised successor to the core's single-outstanding AXI master adapter. It bridges one cache-line or single-word request stream to one AXI4 master port.
- AXI data width is independent of line width, so a line takes LINE_WIDTH/AXI_DATA_WIDTH beats.
- Requests are registered on acceptance. The response side has valid/ready backpressure. Bus errors are reported.
- Read bursts are either INCR from the line base or WRAP critical-word-first. The critical beat is forwarded early.

---
 rtl/ariane_axi.sv | 51 +++++
 rtl/axi_line_port.sv | 200 ++++++++++++++++++++
 tb/tb_axi_line_port.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_axi.sv
// ariane_axi: AXI4 request/response channel structs used by the line port
package ariane_axi;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ax_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;

    typedef struct packed {
        logic aw_ready;
        logic ar_ready;
        logic w_ready;
        logic b_valid;
        b_t   b;
        logic r_valid;
        r_t   r;
    } resp_t;

endpackage

// File: rtl/axi_line_port.sv
// axi_line_port: single-outstanding bridge from a line/word request stream to one AXI4 master port
module axi_line_port #(
    parameter int unsigned LINE_WIDTH     = 256,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter bit          WRAP_READ      = 1'b0,
    parameter type         axi_req_t      = ariane_axi::req_t,
    parameter type         axi_resp_t     = ariane_axi::resp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_we_i,
    input  logic                      req_line_i,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [2:0]                req_size_i,
    input  logic [AXI_ID_WIDTH-1:0]   req_id_i,
    input  logic [LINE_WIDTH-1:0]     req_wdata_i,
    input  logic [LINE_WIDTH/8-1:0]   req_be_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_we_o,
    output logic [AXI_ID_WIDTH-1:0]   rsp_id_o,
    output logic                      rsp_err_o,
    output logic [LINE_WIDTH-1:0]     rsp_rdata_o,
    output logic                      cw_valid_o,
    output logic [AXI_DATA_WIDTH-1:0] cw_data_o,
    output axi_req_t                  axi_req_o,
    input  axi_resp_t                 axi_resp_i
);

    localparam int unsigned BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned DB    = AXI_DATA_WIDTH / 8;
    localparam int unsigned LB    = LINE_WIDTH / 8;
    localparam int unsigned LSIZE = $clog2(DB);
    localparam int unsigned BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int unsigned CW    = BW + 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] LINE_MASK = ~AXI_ADDR_WIDTH'(LB - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_MASK = ~AXI_ADDR_WIDTH'(DB - 1);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RESP} state_e;

    state_e                    state_q, state_d;
    logic                      we_q, we_d, line_q, line_d, a_done_q, a_done_d, err_q, err_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]                size_q, size_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic [LINE_WIDTH-1:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic [LINE_WIDTH/8-1:0]   be_q, be_d;
    logic [BW-1:0]             off_q, off_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic [CW-1:0] n_beats;
    logic [BW-1:0] widx, ridx;
    logic          aw_v, w_v, ar_v, r_rdy, w_last;
    logic          req_hs, aw_hs, w_hs, ar_hs, r_hs, b_hs, aw_end, w_end;
    logic          unused_resp;

    assign n_beats = line_q ? CW'(BEATS) : CW'(1);
    assign widx    = line_q ? cnt_q[BW-1:0] : off_q;
    assign ridx    = !line_q ? off_q : WRAP_READ ? off_q + cnt_q[BW-1:0] : cnt_q[BW-1:0];
    assign aw_v    = state_q == WRITE && !a_done_q;
    assign w_v     = state_q == WRITE && cnt_q < n_beats;
    assign ar_v    = state_q == READ && !a_done_q;
    assign r_rdy   = state_q == READ && a_done_q;
    assign w_last  = !line_q || cnt_q == CW'(BEATS - 1);
    assign req_hs  = state_q == IDLE && req_valid_i;
    assign aw_hs   = aw_v && axi_resp_i.aw_ready;
    assign w_hs    = w_v && axi_resp_i.w_ready;
    assign ar_hs   = ar_v && axi_resp_i.ar_ready;
    assign r_hs    = r_rdy && axi_resp_i.r_valid;
    assign b_hs    = state_q == WRESP && axi_resp_i.b_valid;
    assign aw_end  = a_done_q || aw_hs;
    assign w_end   = cnt_q == n_beats || (w_hs && w_last);
    assign unused_resp = ^{axi_resp_i.b.id, axi_resp_i.r.id, axi_resp_i.b.resp[0], axi_resp_i.r.resp[0]};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: AW and W complete independently, read ends on r_last
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = req_we_i ? WRITE : READ;
            WRITE:   if (aw_end && w_end) state_d = WRESP;
            WRESP:   if (b_hs) state_d = RESP;
            READ:    if (r_hs && axi_resp_i.r.last) state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: AXI channels and response port decoded from state and captured request
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw_valid = aw_v;
        axi_req_o.aw.id    = id_q;
        axi_req_o.aw.addr  = line_q ? addr_q & LINE_MASK : addr_q;
        axi_req_o.aw.len   = line_q ? 8'(BEATS - 1) : 8'd0;
        axi_req_o.aw.size  = line_q ? 3'(LSIZE) : size_q;
        axi_req_o.aw.burst = 2'b01;
        axi_req_o.w_valid  = w_v;
        axi_req_o.w.data   = wdata_q[widx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        axi_req_o.w.strb   = be_q[widx*DB +: DB];
        axi_req_o.w.last   = w_last;
        axi_req_o.b_ready  = state_q == WRESP;
        axi_req_o.ar_valid = ar_v;
        axi_req_o.ar.id    = id_q;
        axi_req_o.ar.addr  = !line_q ? addr_q : WRAP_READ ? addr_q & BEAT_MASK : addr_q & LINE_MASK;
        axi_req_o.ar.len   = line_q ? 8'(BEATS - 1) : 8'd0;
        axi_req_o.ar.size  = line_q ? 3'(LSIZE) : size_q;
        axi_req_o.ar.burst = line_q && WRAP_READ && BEATS > 1 ? 2'b10 : 2'b01;
        axi_req_o.r_ready  = r_rdy;
        req_ready_o        = state_q == IDLE;
        rsp_valid_o        = state_q == RESP;
        rsp_we_o           = we_q;
        rsp_id_o           = id_q;
        rsp_err_o          = err_q;
        rsp_rdata_o        = rdata_q;
        cw_valid_o         = r_hs && line_q && ridx == off_q && cnt_q < n_beats;
        cw_data_o          = axi_resp_i.r.data;
    end

    // Datapath next values: capture, beat counting, slot fill and error accumulation
    always_comb begin
        we_d     = we_q;
        line_d   = line_q;
        addr_d   = addr_q;
        size_d   = size_q;
        id_d     = id_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        a_done_d = a_done_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        if (req_hs) begin
            we_d     = req_we_i;
            line_d   = req_line_i;
            addr_d   = req_addr_i;
            size_d   = req_size_i;
            id_d     = req_id_i;
            wdata_d  = req_wdata_i;
            be_d     = req_be_i;
            off_d    = BW'(req_addr_i >> LSIZE) & BW'(BEATS - 1);
            cnt_d    = '0;
            a_done_d = 1'b0;
            err_d    = 1'b0;
            rdata_d  = '0;
        end
        if (aw_hs || ar_hs) a_done_d = 1'b1;
        if (w_hs) cnt_d = cnt_q + 1'b1;
        if (b_hs) err_d = axi_resp_i.b.resp[1];
        if (r_hs) begin
            err_d = err_q | axi_resp_i.r.resp[1] | (axi_resp_i.r.last ^ (cnt_q == n_beats - 1'b1));
            if (cnt_q < n_beats) begin
                rdata_d[ridx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = axi_resp_i.r.data;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q     <= 1'b0;
            line_q   <= 1'b0;
            addr_q   <= '0;
            size_q   <= '0;
            id_q     <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            a_done_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            we_q     <= we_d;
            line_q   <= line_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            id_q     <= id_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            a_done_q <= a_done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi_line_port.sv
// tb_axi_line_port: randomized self-checking bench for axi_line_port, INCR (unit 0) and WRAP (unit 1) builds
module tb_axi_line_port;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              req_valid [2];
    logic              req_ready [2];
    logic              req_we    [2];
    logic              req_line  [2];
    logic [63:0]       req_addr  [2];
    logic [2:0]        req_size  [2];
    logic [3:0]        req_id    [2];
    logic [255:0]      req_wdata [2];
    logic [31:0]       req_be    [2];
    logic              rsp_valid [2];
    logic              rsp_ready [2];
    logic              rsp_we    [2];
    logic [3:0]        rsp_id    [2];
    logic              rsp_err   [2];
    logic [255:0]      rsp_rdata [2];
    logic              cw_valid  [2];
    logic [63:0]       cw_data   [2];
    ariane_axi::req_t  axi_req   [2];
    ariane_axi::resp_t axi_resp  [2];

    int n_chk, n_fail;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_line_port #(.WRAP_READ(g == 1)) dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_we_i    (req_we[g]),
            .req_line_i  (req_line[g]),
            .req_addr_i  (req_addr[g]),
            .req_size_i  (req_size[g]),
            .req_id_i    (req_id[g]),
            .req_wdata_i (req_wdata[g]),
            .req_be_i    (req_be[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_we_o    (rsp_we[g]),
            .rsp_id_o    (rsp_id[g]),
            .rsp_err_o   (rsp_err[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .cw_valid_o  (cw_valid[g]),
            .cw_data_o   (cw_data[g]),
            .axi_req_o   (axi_req[g]),
            .axi_resp_i  (axi_resp[g])
        );
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_we[u]    = 1'b0;
            req_line[u]  = 1'b0;
            req_addr[u]  = '0;
            req_size[u]  = '0;
            req_id[u]    = '0;
            req_wdata[u] = '0;
            req_be[u]    = '0;
            rsp_ready[u] = 1'b0;
            axi_resp[u]  = '0;
        end
    endtask

    task automatic recover();
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle_valids(input string tag, input int u);
        check({tag, "_aw_valid"}, axi_req[u].aw_valid, 0);
        check({tag, "_w_valid"}, axi_req[u].w_valid, 0);
        check({tag, "_ar_valid"}, axi_req[u].ar_valid, 0);
        check({tag, "_r_ready"}, axi_req[u].r_ready, 0);
        check({tag, "_b_ready"}, axi_req[u].b_ready, 0);
        check({tag, "_rsp_valid"}, rsp_valid[u], 0);
        check({tag, "_cw_valid"}, cw_valid[u], 0);
        check({tag, "_req_ready"}, req_ready[u], 1);
    endtask

    // Hold the response for `wait_c` cycles, then consume it and check the idle bubble
    task automatic finish_rsp(input int u, input bit we, input logic [3:0] id, input bit err,
                              input logic [255:0] rd, input logic [255:0] mask, input int wait_c);
        for (int i = 0; i <= wait_c; i++) begin
            check("rsp_valid", rsp_valid[u], 1);
            check("rsp_busy_req_ready", req_ready[u], 0);
            check("rsp_we", rsp_we[u], we);
            check("rsp_id", rsp_id[u], id);
            check("rsp_err", rsp_err[u], err);
            if (!we) check("rsp_rdata", rsp_rdata[u] & mask, rd & mask);
            if (i == wait_c) rsp_ready[u] = 1'b1;
            @(negedge clk);
        end
        rsp_ready[u] = 1'b0;
        check("bubble_rsp_valid", rsp_valid[u], 0);
        check("bubble_req_ready", req_ready[u], 1);
    endtask

    // Read request against the line model: slot of beat b follows from the burst addressing rules
    task automatic rd(input int u, input logic [63:0] addr, input bit line, input logic [2:0] size,
                      input int nret, input int err_beat, input int ar_wait, input int gap_max, input int rsp_wait);
        int n, off, lat, gaps, slot, g;
        bit wrap, err, cw_exp;
        logic [255:0] exp_line, mask;
        logic [63:0] d, exp_ar;
        logic [3:0] id;
        n = line ? 4 : 1;
        off = int'(addr[4:3]);
        wrap = (u == 1) && line;
        exp_ar = !line ? addr : wrap ? {addr[63:3], 3'b0} : {addr[63:5], 5'b0};
        exp_line = '0;
        mask = '0;
        err = (nret != n);
        gaps = 0;
        id = 4'($urandom);
        check("rd_req_ready", req_ready[u], 1);
        req_valid[u] = 1'b1;
        req_we[u] = 1'b0;
        req_line[u] = line;
        req_addr[u] = addr;
        req_size[u] = size;
        req_id[u] = id;
        @(negedge clk);
        req_valid[u] = 1'b0;
        lat = 1;
        for (int i = 0; i < 4 && !axi_req[u].ar_valid; i++) begin
            @(negedge clk);
            lat++;
        end
        check("ar_valid", axi_req[u].ar_valid, 1);
        if (!axi_req[u].ar_valid) begin
            recover();
            return;
        end
        check("ar_addr", axi_req[u].ar.addr, exp_ar);
        check("ar_len", axi_req[u].ar.len, line ? 3 : 0);
        check("ar_size", axi_req[u].ar.size, line ? 3 : size);
        check("ar_burst", axi_req[u].ar.burst, wrap ? 2 : 1);
        check("ar_id", axi_req[u].ar.id, id);
        check("r_ready_pre_ar", axi_req[u].r_ready, 0);
        for (int i = 0; i < ar_wait; i++) begin
            @(negedge clk);
            lat++;
            check("ar_hold", axi_req[u].ar_valid, 1);
        end
        axi_resp[u].ar_ready = 1'b1;
        @(negedge clk);
        lat++;
        axi_resp[u].ar_ready = 1'b0;
        for (int b = 0; b < nret; b++) begin
            g = gap_max > 0 ? $urandom_range(0, gap_max) : 0;
            gaps += g;
            repeat (g) begin
                @(negedge clk);
                lat++;
            end
            d = {$urandom, $urandom};
            axi_resp[u].r_valid = 1'b1;
            axi_resp[u].r.data = d;
            axi_resp[u].r.resp = (b == err_beat) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            axi_resp[u].r.last = (b == nret - 1);
            axi_resp[u].r.id = 4'($urandom);
            if (b == err_beat) err = 1'b1;
            #1;
            check("r_ready", axi_req[u].r_ready, 1);
            slot = !line ? off : wrap ? (off + b) % 4 : b;
            cw_exp = line && b < n && slot == off;
            check("cw_valid", cw_valid[u], cw_exp);
            if (cw_exp) check("cw_data", cw_data[u], d);
            if (b < n) begin
                exp_line[slot*64 +: 64] = d;
                mask[slot*64 +: 64] = '1;
            end
            @(negedge clk);
            lat++;
            axi_resp[u].r_valid = 1'b0;
        end
        check("rd_latency", lat, 2 + ar_wait + gaps + nret);
        for (int i = 0; i < 8 && !rsp_valid[u]; i++) @(negedge clk);
        if (!rsp_valid[u]) begin
            check("rd_rsp_timeout", 0, 1);
            recover();
            return;
        end
        check("rd_cw_quiet", cw_valid[u], 0);
        finish_rsp(u, 1'b0, id, err, exp_line, mask, rsp_wait);
    endtask

    // Write request: W beats checked against the captured line, AW delayed independently of W
    task automatic wr(input int u, input logic [63:0] addr, input bit line, input logic [2:0] size,
                      input logic [31:0] be, input int aw_wait, input bit w_rand, input logic [1:0] bresp, input int rsp_wait);
        int n, off, wb, t, k, bd;
        bit aw_seen, w_first;
        logic [255:0] wd;
        logic [3:0] id;
        n = line ? 4 : 1;
        off = int'(addr[4:3]);
        wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        id = 4'($urandom);
        check("wr_req_ready", req_ready[u], 1);
        req_valid[u] = 1'b1;
        req_we[u] = 1'b1;
        req_line[u] = line;
        req_addr[u] = addr;
        req_size[u] = size;
        req_id[u] = id;
        req_wdata[u] = wd;
        req_be[u] = be;
        @(negedge clk);
        req_valid[u] = 1'b0;
        wb = 0;
        t = 0;
        aw_seen = 1'b0;
        w_first = 1'b0;
        while ((!aw_seen || wb < n) && t < 60) begin
            if (!aw_seen && axi_req[u].aw_valid) begin
                check("aw_addr", axi_req[u].aw.addr, line ? {addr[63:5], 5'b0} : addr);
                check("aw_len", axi_req[u].aw.len, line ? 3 : 0);
                check("aw_size", axi_req[u].aw.size, line ? 3 : size);
                check("aw_burst", axi_req[u].aw.burst, 1);
                check("aw_id", axi_req[u].aw.id, id);
            end
            if (aw_seen) check("aw_drop", axi_req[u].aw_valid, 0);
            if (wb >= n) check("w_extra", axi_req[u].w_valid, 0);
            axi_resp[u].aw_ready = (t >= aw_wait);
            axi_resp[u].w_ready = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axi_req[u].w_valid && axi_resp[u].w_ready && wb < n) begin
                k = line ? wb : off;
                check("w_data", axi_req[u].w.data, wd[k*64 +: 64]);
                check("w_strb", axi_req[u].w.strb, be[k*8 +: 8]);
                check("w_last", axi_req[u].w.last, wb == n - 1);
                wb++;
            end
            if (axi_req[u].aw_valid && axi_resp[u].aw_ready && !aw_seen) begin
                aw_seen = 1'b1;
                w_first = (wb == n);
            end
            @(negedge clk);
            t++;
        end
        axi_resp[u].aw_ready = 1'b0;
        axi_resp[u].w_ready = 1'b0;
        check("wr_done", aw_seen && wb == n, 1);
        if (!(aw_seen && wb == n)) begin
            recover();
            return;
        end
        if (aw_wait >= 6 && !w_rand) check("w_before_aw", w_first, 1);
        bd = $urandom_range(0, 2);
        for (int i = 0; i <= bd; i++) begin
            check("b_ready", axi_req[u].b_ready, 1);
            check("wresp_w_valid", axi_req[u].w_valid, 0);
            if (i == bd) begin
                axi_resp[u].b_valid = 1'b1;
                axi_resp[u].b.resp = bresp;
                axi_resp[u].b.id = 4'($urandom);
            end
            @(negedge clk);
        end
        axi_resp[u].b_valid = 1'b0;
        check("resp_b_ready", axi_req[u].b_ready, 0);
        finish_rsp(u, 1'b1, id, bresp[1], '0, '0, rsp_wait);
    endtask

    // Reset mid-burst: everything drops asynchronously and the port is immediately ready
    task automatic rst_mid(input int u);
        req_valid[u] = 1'b1;
        req_we[u] = 1'b0;
        req_line[u] = 1'b1;
        req_addr[u] = 64'h1000;
        @(negedge clk);
        req_valid[u] = 1'b0;
        axi_resp[u].ar_ready = 1'b1;
        @(negedge clk);
        axi_resp[u].ar_ready = 1'b0;
        axi_resp[u].r_valid = 1'b1;
        axi_resp[u].r.data = {$urandom, $urandom};
        axi_resp[u].r.last = 1'b0;
        @(negedge clk);
        axi_resp[u].r_valid = 1'b0;
        check("rst_pre_r_ready", axi_req[u].r_ready, 1);
        rst_n = 1'b0;
        #1;
        idle_valids("rst_mid", u);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_rdata", rsp_rdata[u], 0);
        check("rst_err", rsp_err[u], 0);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, nret, k;
        bit line;
        logic [63:0] a;
        n_chk = 0;
        n_fail = 0;
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            idle_valids("reset", u);
            check("reset_rdata", rsp_rdata[u], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            rd(u, 64'h1028, 1'b1, 3'd3, 4, -1, 0, 0, 0);
            wr(u, 64'h3000, 1'b1, 3'd3, $urandom, 6, 1'b0, 2'b00, 0);
            wr(u, 64'h2010, 1'b0, 3'd2, 32'h000F_0000, 0, 1'b0, 2'b00, 0);
            rd(u, 64'h1048, 1'b1, 3'd3, 4, 2, 0, 0, 0);
            rd(u, 64'h1008, 1'b1, 3'd3, 2, -1, 0, 0, 0);
            rd(u, 64'h1010, 1'b1, 3'd3, 6, -1, 1, 1, 0);
            rd(u, 64'h1018, 1'b1, 3'd3, 4, -1, 0, 0, 5);
            rd(u, 64'h2014, 1'b0, 3'd2, 1, -1, 0, 0, 1);
            wr(u, 64'h4008, 1'b1, 3'd3, $urandom, 0, 1'b1, 2'b10, 2);
            rst_mid(u);
            rd(u, 64'h1030, 1'b1, 3'd3, 4, -1, 0, 0, 0);
        end
        for (int i = 0; i < 40; i++) begin
            int u;
            u = $urandom_range(0, 1);
            line = 1'($urandom_range(0, 1));
            a = {32'h0, $urandom};
            n = line ? 4 : 1;
            if ($urandom_range(0, 1) == 1) begin
                wr(u, a, line, 3'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3), 1'b1,
                   2'($urandom_range(0, 3)), $urandom_range(0, 3));
            end else begin
                k = $urandom_range(0, 5);
                nret = (k == 0 && n > 1) ? n - 1 : (k == 1) ? n + 1 : n;
                rd(u, a, line, 3'($urandom_range(0, 3)), nret,
                   $urandom_range(0, 2) == 0 ? $urandom_range(0, nret - 1) : -1,
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
